// File: rtl/proc_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : proc_trace_buf
// Description : Instruction-retirement trace buffer. It captures retired
//               instruction records into a circular FIFO. An optional filter
//               keeps only records that write the register file. It also
//               counts retired instructions and records dropped on a full
//               buffer, and holds a sticky overflow flag.
// Ports       : clk, rst (sync, active-low)
//               trace_val/addr/inst/wen/wreg/wdata : retirement input
//               wen_only : capture only records with effective wen
//               clr      : synchronous flush of FIFO and counters
//               deq_val/rdy, deq_addr/inst/wen/wreg/wdata : head record
//               occupancy, retired, dropped, overflow : status
// Revision    : 1.0 - initial release
// ============================================================================
module proc_trace_buf #(
    parameter int DEPTH = 8,   // power of two, >= 2
    parameter int DROPW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_inst,
    input  logic                     trace_wen,
    input  logic [4:0]               trace_wreg,
    input  logic [31:0]              trace_wdata,
    input  logic                     wen_only,
    input  logic                     clr,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [31:0]              deq_addr,
    output logic [31:0]              deq_inst,
    output logic [31:0]              deq_wdata,
    output logic                     deq_wen,
    output logic [4:0]               deq_wreg,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              retired,
    output logic [DROPW-1:0]         dropped,
    output logic                     overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int OW   = AW + 1;
    localparam int RECW = 102;   // addr(32) inst(32) wen(1) wreg(5) wdata(32)

    localparam logic [OW-1:0]    C_DEPTH    = OW'(DEPTH);
    localparam logic [DROPW-1:0] C_DROP_MAX = '1;

    logic [RECW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [31:0]      retired_q, retired_d;
    logic [DROPW-1:0] dropped_q, dropped_d;
    logic             overflow_q, overflow_d;

    logic             w_eff_wen;
    logic             w_cand;
    logic             w_deq;
    logic             w_enq;
    logic             w_drop;
    logic [RECW-1:0]  w_rec;
    logic [RECW-1:0]  w_head_rec;

    always_comb begin
        // A write to x0 is architecturally a no-op, so it does not count as a write.
        w_eff_wen = trace_wen && (trace_wreg != 5'd0);
        w_cand    = trace_val && (!wen_only || w_eff_wen);
        w_deq     = (occ_q != '0) && deq_rdy;
        // When the buffer is full, a same-cycle dequeue frees the slot that the new record takes.
        w_enq     = w_cand && ((occ_q != C_DEPTH) || w_deq);
        w_drop    = w_cand && !w_enq;
        w_rec     = {trace_addr, trace_inst, w_eff_wen, trace_wreg, trace_wdata};

        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        retired_d  = retired_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;

        if (clr) begin
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
            retired_d  = '0;
            dropped_d  = '0;
            overflow_d = 1'b0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (w_deq) head_d = head_q + 1'b1;
            if (w_enq) tail_d = tail_q + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (trace_val) retired_d = retired_q + 32'd1;
            if (w_drop) begin
                overflow_d = 1'b1;
                if (dropped_q != C_DROP_MAX) dropped_d = dropped_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            retired_q  <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            retired_q  <= retired_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // The storage array is not reset. The pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (rst && !clr && w_enq) begin
            mem_q[tail_q] <= w_rec;
        end
    end

    assign w_head_rec = mem_q[head_q];

    assign deq_val   = (occ_q != '0);
    assign deq_addr  = w_head_rec[101:70];
    assign deq_inst  = w_head_rec[69:38];
    assign deq_wen   = w_head_rec[37];
    assign deq_wreg  = w_head_rec[36:32];
    assign deq_wdata = w_head_rec[31:0];

    assign occupancy = occ_q;
    assign retired   = retired_q;
    assign dropped   = dropped_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_trace_buf
// Description : Self-checking scoreboard bench for proc_trace_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_trace_buf;

    localparam int DEPTH = 8;
    localparam int DROPW = 4;
    localparam int DMAX  = (1 << DROPW) - 1;

    logic        clk;
    logic        rst;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_inst;
    logic        trace_wen;
    logic [4:0]  trace_wreg;
    logic [31:0] trace_wdata;
    logic        wen_only;
    logic        clr;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_addr;
    logic [31:0] deq_inst;
    logic [31:0] deq_wdata;
    logic        deq_wen;
    logic [4:0]  deq_wreg;
    logic [3:0]  occupancy;
    logic [31:0] retired;
    logic [DROPW-1:0] dropped;
    logic        overflow;

    proc_trace_buf #(.DEPTH(DEPTH), .DROPW(DROPW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .trace_val   (trace_val),
        .trace_addr  (trace_addr),
        .trace_inst  (trace_inst),
        .trace_wen   (trace_wen),
        .trace_wreg  (trace_wreg),
        .trace_wdata (trace_wdata),
        .wen_only    (wen_only),
        .clr         (clr),
        .deq_val     (deq_val),
        .deq_rdy     (deq_rdy),
        .deq_addr    (deq_addr),
        .deq_inst    (deq_inst),
        .deq_wdata   (deq_wdata),
        .deq_wen     (deq_wen),
        .deq_wreg    (deq_wreg),
        .occupancy   (occupancy),
        .retired     (retired),
        .dropped     (dropped),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [101:0] sb[$];
    int           m_occ;
    logic [31:0]  m_ret;
    int           m_drop;
    bit           m_ovf;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] i,
                         input bit w, input logic [4:0] r, input logic [31:0] d);
        trace_val   = v;
        trace_addr  = a;
        trace_inst  = i;
        trace_wen   = w;
        trace_wreg  = r;
        trace_wdata = d;
    endtask

    // One clock: predict from current inputs, check the head before the edge,
    // then check the status outputs after the edge.
    task automatic cycle();
        bit ew, cand, dq, eq;
        logic [101:0] exp_rec;
        #1;
        if (!rst) begin
            sb.delete();
            m_occ = 0; m_ret = '0; m_drop = 0; m_ovf = 1'b0;
        end else begin
            check("deq_val_pre", deq_val, m_occ != 0);
            dq = (m_occ != 0) && deq_rdy;
            if (dq && !clr) begin
                exp_rec = sb.pop_front();
                check("deq_rec", {deq_addr, deq_inst, deq_wen, deq_wreg, deq_wdata}, exp_rec);
            end
            if (clr) begin
                sb.delete();
                m_occ = 0; m_ret = '0; m_drop = 0; m_ovf = 1'b0;
            end else begin
                ew   = trace_wen && (trace_wreg != 5'd0);
                cand = trace_val && (!wen_only || ew);
                eq   = cand && ((m_occ < DEPTH) || dq);
                if (eq) sb.push_back({trace_addr, trace_inst, ew, trace_wreg, trace_wdata});
                m_occ = m_occ + int'(eq) - int'(dq);
                if (trace_val) m_ret = m_ret + 32'd1;
                if (cand && !eq) begin
                    m_ovf = 1'b1;
                    if (m_drop < DMAX) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        check("occupancy", occupancy, m_occ);
        check("retired", retired, m_ret);
        check("dropped", dropped, m_drop);
        check("overflow", overflow, m_ovf);
        check("deq_val", deq_val, m_occ != 0);
    endtask

    task automatic do_clr();
        drive(0, 0, 0, 0, 0, 0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; wen_only = 1'b0; deq_rdy = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Reset state
        cycle();
        cycle();
        check("rst_occ", occupancy, 0);
        check("rst_deq_val", deq_val, 0);
        rst = 1'b1;

        // Single capture
        drive(1, 32'h0000_0008, 32'h0010_0093, 1, 5'd1, 32'd1);
        cycle();
        check("cap_val", deq_val, 1);
        check("cap_addr", deq_addr, 32'h0000_0008);
        check("cap_inst", deq_inst, 32'h0010_0093);
        check("cap_wen", deq_wen, 1);
        check("cap_wreg", deq_wreg, 1);
        check("cap_wdata", deq_wdata, 1);
        check("cap_occ", occupancy, 1);
        check("cap_ret", retired, 1);
        drive(0, 0, 0, 0, 0, 0);
        deq_rdy = 1'b1;
        cycle();

        // Filter drops stores and writes to x0
        do_clr();
        wen_only = 1'b1;
        deq_rdy  = 1'b0;
        drive(1, 32'h10, 32'h0020_a023, 0, 5'd5, 32'h55);
        cycle();
        drive(1, 32'h14, 32'h0010_0013, 1, 5'd0, 32'h1);
        cycle();
        check("flt_occ", occupancy, 0);
        check("flt_ret", retired, 2);
        check("flt_drop", dropped, 0);
        wen_only = 1'b0;

        // Overflow, then drain in order
        do_clr();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1000 + i, 32'h13, 1, 5'd3, i);
            cycle();
        end
        check("ovf_occ", occupancy, 8);
        check("ovf_drop", dropped, 2);
        check("ovf_flag", overflow, 1);
        drive(0, 0, 0, 0, 0, 0);
        deq_rdy = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("ovf_empty", deq_val, 0);

        // Full with simultaneous dequeue
        do_clr();
        deq_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h2000 + i, 32'h13, 1, 5'd4, i);
            cycle();
        end
        deq_rdy = 1'b1;
        drive(1, 32'h100, 32'h33, 1, 5'd7, 32'hABCD);
        cycle();
        check("fd_occ", occupancy, 8);
        check("fd_drop", dropped, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle();
        check("fd_last_addr", deq_addr, 32'h100);
        cycle();
        check("fd_empty", deq_val, 0);

        // Wrap-around at occupancy 3
        do_clr();
        deq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h3000 + i, 32'h13, 1, 5'd8, i);
            cycle();
        end
        deq_rdy = 1'b1;
        for (int i = 3; i < 23; i++) begin
            drive(1, 32'h3000 + i, 32'h13, 1, 5'd8, i);
            cycle();
        end
        check("wrap_occ", occupancy, 3);

        // Drop counter saturation
        do_clr();
        deq_rdy = 1'b0;
        for (int i = 0; i < 28; i++) begin
            drive(1, 32'h4000 + i, 32'h13, 0, 5'd0, i);
            cycle();
        end
        check("sat_drop", dropped, DMAX);
        check("sat_ovf", overflow, 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
            deq_rdy  = $urandom_range(0, 2) != 0;
            wen_only = $urandom_range(0, 7) == 0;
            clr      = $urandom_range(0, 63) == 0;
            cycle();
        end
        clr = 1'b0; wen_only = 1'b0;

        // Reset mid-operation, then clr with a simultaneous trace input
        do_clr();
        deq_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h5000 + i, 32'h13, 1, 5'd9, i);
            cycle();
        end
        check("pre_rst_occ", occupancy, 5);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle();
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_ret", retired, 0);
        check("mid_rst_drop", dropped, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_val", deq_val, 0);
        rst = 1'b1;
        clr = 1'b1;
        drive(1, 32'h6000, 32'h13, 1, 5'd2, 32'h6);
        cycle();
        clr = 1'b0;
        check("clr_occ", occupancy, 0);
        check("clr_ret", retired, 0);
        drive(1, 32'h7000, 32'h13, 1, 5'd2, 32'h7);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        deq_rdy = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
